riscv_mem_arbiter: RTL
======================

Name: riscv_mem_arbiter

Overview:
- Shares one fixed-latency memory macro between the instruction-fetch port and the data-memory port of the core.
- Accepts level requests from both ports and grants one at a time. Data port wins by default.
- Holds memory strobes for LATENCY cycles, then returns a one-cycle ready pulse with registered read data to the granted port.
- Replaces per-port latency counting. The core stalls on ready low.

Parameters:
- DW, 64, data width (bits); DW divisible by 8
- AW, 64, address width (bits)
- LATENCY, 3, memory access cycles; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_rden  in  1  fetch read request (level)
- if_addr  in  AW  fetch address
- if_ready  out  1  fetch response pulse
- if_rdata  out  DW  fetch read data, valid with if_ready
- dm_rden  in  1  data read request (level)
- dm_wren  in  1  data write request (level)
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_be  in  DW/8  write byte enables
- dm_ready  out  1  data response pulse (read or write ack)
- dm_rdata  out  DW  data read data, valid with dm_ready
- mem_rden  out  1  memory read strobe
- mem_wren  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables
- mem_rdata  in  DW  memory read data, valid at end of last access cycle
- arb_busy  out  1  high in BUSY and RESP states

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs are 0: ready pulses, strobes, mem_addr/wdata/be, if_rdata, dm_rdata, arb_busy.
  - Internal counter and grant register are cleared.
  - Reset mid-access abandons the transaction. No ready is issued for it.
- States and transitions:
  - IDLE:
    - Sample requests. dm_req = dm_rden | dm_wren.
    - If any request is pending, latch the winner's address, operation, wdata and be into internal registers, record the grant, clear the counter, and go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - mem_rden or mem_wren is held high together with the latched mem_addr, mem_wdata and mem_be.
    - The counter increments each cycle.
    - On the cycle with counter == LATENCY-1:
      - capture mem_rdata into the granted port's rdata register (reads only);
      - drop the strobes;
      - go to RESP.
  - RESP:
    - Granted port's ready = 1 for exactly one cycle. Go to IDLE.
- Timing:
  - A request sampled in IDLE at cycle 0 gives strobes high in cycles 1..LATENCY and ready in cycle LATENCY+1. Default is ready at cycle 4.
  - The next grant happens no earlier than cycle LATENCY+2.
- Request signals:
  - Requesters need not hold address or data after the grant cycle.
  - A request still high in IDLE after its ready pulse is treated as a new transaction.
- Default arbitration is fixed priority: dm beats if when both request in the same IDLE cycle.
- dm_rden and dm_wren high together: performed as a write. dm_ready pulses; dm_rdata is unchanged.
- Write responses:
  - dm_ready pulses; dm_rdata keeps its previous value.
  - if_rdata and dm_rdata hold their last captured value until overwritten.
- Request edges:
  - A request that drops while BUSY has no effect on the in-flight access.
  - A request that rises during BUSY or RESP waits for IDLE.
- LATENCY=1: a single BUSY cycle.
- Counter width: 4 bits, no wrap possible within the legal range.

Optional Feature:
- Macro RISCV_ARB_ROUND_ROBIN_EN.
- When defined:
  - A last-grant flop (reset to if) is updated at every grant.
  - When both ports request in the same IDLE cycle, the port not granted last wins.
  - Guarantees alternation under continuous contention.
- When undefined: fixed dm-over-if priority. No last-grant flop is synthesized.

Test Plan:
- Single fetch, LATENCY=3:
  - Stimulus: if_rden=1, if_addr=0x100 at cycle 0; memory returns 0xDEAD_BEEF.
  - Required: mem_rden high cycles 1-3 with mem_addr=0x100; if_ready=1 only at cycle 4; if_rdata=0xDEAD_BEEF.
- Single write:
  - Stimulus: dm_wren=1, dm_addr=0x200, dm_wdata=0x1234, dm_be=0x0F.
  - Required: mem_wren high cycles 1-3 with those values; dm_ready at cycle 4; dm_rdata unchanged; if_ready stays 0.
- Simultaneous requests, if_rden and dm_rden both held high:
  - Without macro: dm served first (ready cycle 4), then if (ready cycle 9).
  - With RISCV_ARB_ROUND_ROBIN_EN, both held continuously: grants alternate dm, if, dm, if.
- Reset mid-access:
  - Stimulus: rst=1 at cycle 2 of an if read.
  - Required: next cycle all strobes 0, arb_busy 0, no if_ready ever issued; a fresh request after reset completes normally.
- Back-to-back fetch:
  - Stimulus: if_rden held high across 3 transactions, addresses 0x0, 0x8, 0x10.
  - Required: three if_ready pulses spaced LATENCY+2=5 cycles apart with matching data.
- LATENCY=1 build:
  - Stimulus: single dm read.
  - Required: mem_rden high cycle 1 only; dm_ready at cycle 2.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one fixed-latency memory macro between the
// instruction-fetch port and the data-memory port. One access at a time:
// IDLE -> BUSY (LATENCY cycles of strobes) -> RESP (one-cycle ready pulse).
// Data port wins by default. Define RISCV_ARB_ROUND_ROBIN_EN to alternate
// grants under contention instead.
module riscv_mem_arbiter #(
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_rden,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_rden,
  input  logic            dm_wren,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_ready,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_rden,
  output logic            mem_wren,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output logic            arb_busy
);

  localparam int         BW       = DW / 8;
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            grant_dm_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic            mem_rden_q;
  logic            mem_wren_q;
  logic            if_ready_q;
  logic            dm_ready_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   dm_rdata_q;
  logic            dm_req;
  logic            any_req;
  logic            grant_dm_d;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
  // Last port granted; 0 = fetch, 1 = data. Resets to fetch so data wins first.
  logic            last_dm_q;
`endif

  assign dm_req  = dm_rden | dm_wren;
  assign any_req = dm_req | if_rden;

  // Pick the winner of the current IDLE-cycle arbitration.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_dm_d = 1'b0;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
    grant_dm_d = dm_req & ~(if_rden & last_dm_q);
`else
    grant_dm_d = dm_req;
`endif
  end

`ifdef RISCV_ARB_ROUND_ROBIN_EN
  // Remember who won the last grant so contention alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      last_dm_q <= grant_dm_d;
    end
  end
`endif

  // Arbitration FSM with registered strobes, ready pulses and read data.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grant_dm_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_rden_q <= 1'b0;
      mem_wren_q <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            // Simultaneous rden/wren on the data port is performed as a write.
            grant_dm_q <= grant_dm_d;
            wr_q       <= grant_dm_d & dm_wren;
            addr_q     <= grant_dm_d ? dm_addr : if_addr;
            wdata_q    <= grant_dm_d ? dm_wdata : '0;
            be_q       <= grant_dm_d ? dm_be : '0;
            mem_rden_q <= ~(grant_dm_d & dm_wren);
            mem_wren_q <= grant_dm_d & dm_wren;
            cnt_q      <= '0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            if (!wr_q) begin
              if (grant_dm_q) dm_rdata_q <= mem_rdata;
              else            if_rdata_q <= mem_rdata;
            end
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            if_ready_q <= ~grant_dm_q;
            dm_ready_q <= grant_dm_q;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rden  = mem_rden_q;
  assign mem_wren  = mem_wren_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign arb_busy  = (state_q == S_BUSY) || (state_q == S_RESP);

endmodule
